// File: rtl/tcdm_interconnect_wrap_pkg.sv
// Width helpers shared by the TCDM interconnect and its per-bank arbiter.
package tcdm_interconnect_wrap_pkg;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned byte_off_bits(input int unsigned data_width);
    return $clog2(data_width - 1) - 3;
  endfunction

endpackage

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer; the pointer moves past the winner only when the grant is consumed.
module tcdm_rr_arbiter
  import tcdm_interconnect_wrap_pkg::*;
#(
  parameter int unsigned  NumIn = 16,
  localparam int unsigned IdxW  = idx_bits(NumIn)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] req_i,
  input  logic             adv_i,
  output logic             req_o,
  output logic [NumIn-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;
  logic            found;

  // NumIn is a power of two, so the IdxW-bit add wraps naturally.
  always_comb begin
    found = 1'b0;
    idx_o = ptr_q;
    cand  = ptr_q;
    for (int unsigned i = 0; i < NumIn; i++) begin
      cand = ptr_q + IdxW'(i);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

  assign req_o = found;
  assign ptr_d = adv_i ? idx_o + IdxW'(1) : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tcdm_interconnect_wrap.sv
// Full crossbar from NumMaster masters to NumMaster*BankFact word-interleaved
// TCDM banks, one round-robin arbiter per bank, one-cycle response path.
module tcdm_interconnect_wrap
  import tcdm_interconnect_wrap_pkg::*;
#(
  parameter int unsigned  NumMaster   = 16,
  parameter int unsigned  BankFact    = 2,
  parameter int unsigned  DataWidth   = 32,
  parameter int unsigned  MemAddrBits = 12,
  localparam int unsigned NumBanks    = NumMaster * BankFact,
  localparam int unsigned BeWidth     = DataWidth / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumMaster-1:0]                  req_i,
  input  logic [NumMaster-1:0][DataWidth-1:0]   add_i,
  input  logic [NumMaster-1:0]                  wen_i,
  input  logic [NumMaster-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumMaster-1:0][BeWidth-1:0]     be_i,
  output logic [NumMaster-1:0]                  gnt_o,
  output logic [NumMaster-1:0]                  vld_o,
  output logic [NumMaster-1:0][DataWidth-1:0]   rdata_o,
  output logic [NumBanks-1:0]                   req_o,
  input  logic [NumBanks-1:0]                   gnt_i,
  output logic [NumBanks-1:0][MemAddrBits-1:0]  add_o,
  output logic [NumBanks-1:0]                   wen_o,
  output logic [NumBanks-1:0][DataWidth-1:0]    wdata_o,
  output logic [NumBanks-1:0][BeWidth-1:0]      be_o,
  input  logic [NumBanks-1:0][DataWidth-1:0]    rdata_i
);

  localparam int unsigned Off        = byte_off_bits(DataWidth);
  localparam int unsigned BankBits   = idx_bits(NumBanks);
  localparam int unsigned MasterBits = idx_bits(NumMaster);

  logic [NumMaster-1:0][BankBits-1:0]    bank_sel;
  logic [NumMaster-1:0][MemAddrBits-1:0] word_sel;
  logic [NumBanks-1:0][NumMaster-1:0]    win_oh;
  logic [NumMaster-1:0]                  vld_q, vld_d;
  logic [NumMaster-1:0][BankBits-1:0]    bank_q, bank_d;
  logic                                  unused_add;

  // Byte-offset and high address bits take no part in routing.
  assign unused_add = ^add_i;

  for (genvar gi = 0; gi < NumMaster; gi++) begin : g_master
    assign bank_sel[gi] = add_i[gi][Off +: BankBits];
    assign word_sel[gi] = add_i[gi][Off + BankBits +: MemAddrBits];
    assign gnt_o[gi]    = req_i[gi] & win_oh[bank_sel[gi]][gi] & gnt_i[bank_sel[gi]];
    assign rdata_o[gi]  = rdata_i[bank_q[gi]];
  end

  for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank
    logic [NumMaster-1:0]  bank_req;
    logic [NumMaster-1:0]  bank_win;
    logic [MasterBits-1:0] win_idx;
    logic                  bank_act;

    for (genvar gm = 0; gm < NumMaster; gm++) begin : g_sel
      assign bank_req[gm] = req_i[gm] & (bank_sel[gm] == BankBits'(gi));
    end

    tcdm_rr_arbiter #(
      .NumIn (NumMaster)
    ) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (bank_req),
      .adv_i  (bank_act & gnt_i[gi]),
      .req_o  (bank_act),
      .gnt_o  (bank_win),
      .idx_o  (win_idx)
    );

    assign win_oh[gi]  = bank_win;
    assign req_o[gi]   = bank_act;
    assign add_o[gi]   = word_sel[win_idx];
    assign wen_o[gi]   = wen_i[win_idx];
    assign wdata_o[gi] = wdata_i[win_idx];
    assign be_o[gi]    = be_i[win_idx];
  end

  // Remember which bank answers each master one cycle after its grant.
  assign vld_d  = gnt_o;
  assign bank_d = bank_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      bank_q <= '0;
    end else begin
      vld_q  <= vld_d;
      bank_q <= bank_d;
    end
  end

  assign vld_o = vld_q;

endmodule

// File: tb/tb_tcdm_interconnect_wrap.sv
// Scoreboard bench: reference arbiter/memory model pushes expected responses,
// a monitor pops them whenever vld_o is presented.
module tb_tcdm_interconnect_wrap;
  localparam int NM = 16;
  localparam int NB = 32;
  localparam int DW = 32;
  localparam int MB = 12;
  localparam int NW = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic [NM-1:0]          req_i, wen_i, gnt_o, vld_o;
  logic [NM-1:0][DW-1:0]  add_i, wdata_i, rdata_o;
  logic [NM-1:0][3:0]     be_i;
  logic [NB-1:0]          req_o, gnt_i, wen_o;
  logic [NB-1:0][MB-1:0]  add_o;
  logic [NB-1:0][DW-1:0]  wdata_o, rdata_i;
  logic [NB-1:0][3:0]     be_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t q [NM][$];

  logic [31:0] ref_mem  [NB][NW];
  int          ptr      [NB];
  logic [31:0] bank_mem [NB][NW];
  logic        bank_wr  [NB][NW];

  tcdm_interconnect_wrap #(
    .NumMaster(NM), .BankFact(2), .DataWidth(DW), .MemAddrBits(MB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o),
    .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .wen_o(wen_o),
    .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got 0x%0h, expected 0x%0h", nm, idx, cyc, act, exp);
    end
  endfunction

  function automatic int bank_of(input logic [31:0] a);
    return int'((a / 4) % NB);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / (4 * NB)) % NW);
  endfunction

  function automatic logic [31:0] mk_addr(input int b, input int w);
    return 32'(w * 4 * NB + b * 4);
  endfunction

  function automatic logic [31:0] init_val(input int b, input int w);
    return (32'(b) * 32'h0100_0193) ^ (32'(w) * 32'h9E37_79B9);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bank_rd(input int b, input logic [MB-1:0] w);
    return bank_wr[b][w] ? bank_mem[b][w] : init_val(b, int'(w));
  endfunction

  // Bank emulation: accept on req_o & gnt_i, answer one cycle later.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < NW; w++) bank_wr[b][w] <= 1'b0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (req_o[b] && gnt_i[b]) begin
          rdata_i[b] <= bank_rd(b, add_o[b]);
          if (wen_o[b]) begin
            bank_mem[b][add_o[b]] <= merge(bank_rd(b, add_o[b]), wdata_o[b], be_o[b]);
            bank_wr[b][add_o[b]]  <= 1'b1;
          end
        end
      end
    end
  end

  // Reference model: per-bank rotating priority, expected bank fields and grants.
  always @(negedge clk) begin : ref_check
    int win [NB];
    int m, w;
    logic [NM-1:0] eg;
    if (!rst_n) for (int b = 0; b < NB; b++) ptr[b] = 0;
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      for (int i = 0; i < NM; i++) begin
        m = (ptr[b] + i) % NM;
        if (win[b] < 0 && req_i[m] && bank_of(add_i[m]) == b) win[b] = m;
      end
    end
    eg = '0;
    for (int b = 0; b < NB; b++) begin
      check("req_o", b, 64'(req_o[b]), 64'(win[b] >= 0));
      if (win[b] >= 0) begin
        m = win[b];
        w = word_of(add_i[m]);
        check("add_o", b, 64'(add_o[b]), 64'(w));
        check("wen_o", b, 64'(wen_o[b]), 64'(wen_i[m]));
        check("wdata_o", b, 64'(wdata_o[b]), 64'(wdata_i[m]));
        check("be_o", b, 64'(be_o[b]), 64'(be_i[m]));
        if (gnt_i[b]) begin
          eg[m] = 1'b1;
          if (rst_n) begin
            q[m].push_back('{cyc + 1, ref_mem[b][w]});
            ptr[b] = (m + 1) % NM;
          end
          if (wen_i[m]) ref_mem[b][w] = merge(ref_mem[b][w], wdata_i[m], be_i[m]);
        end
      end
    end
    check("gnt_o", -1, 64'(gnt_o), 64'(eg));
  end

  always @(negedge clk) begin : monitor
    resp_t r;
    if (!rst_n) begin
      for (int m = 0; m < NM; m++) q[m].delete();
      check("vld_o_reset", -1, 64'(vld_o), 64'd0);
    end else begin
      for (int m = 0; m < NM; m++) begin
        if (q[m].size() > 0 && q[m][0].due == cyc) begin
          r = q[m].pop_front();
          check("vld_o", m, 64'(vld_o[m]), 64'd1);
          if (vld_o[m]) check("rdata_o", m, 64'(rdata_o[m]), 64'(r.data));
        end else if (vld_o[m]) begin
          check("vld_o_spurious", m, 64'(vld_o[m]), 64'd0);
        end
      end
    end
  end

  initial begin : stim
    logic [NM-1:0] g;
    int seq [3];
    int waitc [3];
    int bk;
    rst_n = 1'b0; req_i = '0; add_i = '0; wen_i = '0; wdata_i = '0; be_i = '0; gnt_i = '1;
    for (int b = 0; b < NB; b++) begin
      ptr[b] = 0;
      for (int w = 0; w < NW; w++) ref_mem[b][w] = init_val(b, w);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single uncontended read of 0x104 -> bank 1, word 2.
    req_i[0] = 1'b1; add_i[0] = 32'h0000_0104; wen_i[0] = 1'b0; be_i[0] = 4'hF;
    @(negedge clk);
    check("b_gnt0", 0, 64'(gnt_o[0]), 64'd1);
    check("b_req1", 1, 64'(req_o[1]), 64'd1);
    check("b_add1", 1, 64'(add_o[1]), 64'd2);
    check("b_wen1", 1, 64'(wen_o[1]), 64'd0);
    @(posedge clk); #1 req_i = '0;
    @(negedge clk);
    check("b_vld0", 0, 64'(vld_o[0]), 64'd1);
    check("b_rdata0", 0, 64'(rdata_o[0]), 64'(rdata_i[1]));
    @(posedge clk); #1;

    // Conflict-free full throughput: master m -> bank m.
    for (int k = 0; k < 1000; k++) begin
      for (int m = 0; m < NM; m++) begin
        req_i[m] = 1'b1; add_i[m] = mk_addr(m, int'($urandom_range(0, 15)));
        wen_i[m] = 1'($urandom_range(0, 1)); wdata_i[m] = 32'($urandom); be_i[m] = 4'($urandom);
      end
      @(negedge clk);
      check("c_all_gnt", k, 64'(gnt_o), 64'hFFFF);
      if (k > 0) check("c_all_vld", k, 64'(vld_o), 64'hFFFF);
      @(posedge clk); #1;
    end
    req_i = '0;

    // Masters 0, 3, 5 contend for bank 7; its pointer sits at 8 after the sweep above.
    seq = '{0, 3, 5}; waitc = '{0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 3; j++) begin
        req_i[seq[j]] = 1'b1; add_i[seq[j]] = mk_addr(7, j); wen_i[seq[j]] = 1'b0;
      end
      @(negedge clk);
      check("d_rr_gnt", k, 64'(gnt_o), 64'(1 << seq[k % 3]));
      for (int j = 0; j < 3; j++) begin
        if (gnt_o[seq[j]]) waitc[j] = 0; else waitc[j]++;
        check("d_wait_le2", seq[j], 64'(waitc[j] <= 2), 64'd1);
      end
      @(posedge clk); #1;
    end
    req_i = '0;

    // Partial write then readback through master 2, bank 4 word 9.
    req_i[2] = 1'b1; add_i[2] = mk_addr(4, 9); wen_i[2] = 1'b1;
    wdata_i[2] = 32'hDEAD_BEEF; be_i[2] = 4'b0011;
    @(negedge clk);
    check("e_gnt2", 2, 64'(gnt_o[2]), 64'd1);
    check("e_req4", 4, 64'(req_o[4]), 64'd1);
    check("e_add4", 4, 64'(add_o[4]), 64'd9);
    check("e_wen4", 4, 64'(wen_o[4]), 64'd1);
    check("e_be4", 4, 64'(be_o[4]), 64'b0011);
    @(posedge clk); #1 wen_i[2] = 1'b0; be_i[2] = 4'hF;
    @(negedge clk);
    check("e_gnt2_rd", 2, 64'(gnt_o[2]), 64'd1);
    check("e_vld2_wr", 2, 64'(vld_o[2]), 64'd1);
    @(posedge clk); #1 req_i = '0;
    @(negedge clk);
    check("e_vld2_rd", 2, 64'(vld_o[2]), 64'd1);
    check("e_rdata_lo", 2, 64'(rdata_o[2][15:0]), 64'hBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("e_vld2_idle", 2, 64'(vld_o[2]), 64'd0);
    @(posedge clk); #1;

    // Bank 4 stalls master 1 until gnt_i[4] rises.
    req_i[1] = 1'b1; add_i[1] = mk_addr(4, 0); wen_i[1] = 1'b0; gnt_i[4] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("f_gnt1_stall", k, 64'(gnt_o[1]), 64'd0);
      check("f_req4_stall", k, 64'(req_o[4]), 64'd1);
      check("f_vld1_stall", k, 64'(vld_o[1]), 64'd0);
      @(posedge clk); #1;
    end
    gnt_i[4] = 1'b1;
    @(negedge clk);
    check("f_gnt1", 1, 64'(gnt_o[1]), 64'd1);
    @(posedge clk); #1 req_i = '0;
    @(negedge clk);
    check("f_vld1", 1, 64'(vld_o[1]), 64'd1);
    @(posedge clk); #1;

    // Random traffic: hot banks first, then spread; requests held until granted.
    g = '0;
    for (int k = 0; k < 2000; k++) begin
      for (int m = 0; m < NM; m++) begin
        if (!req_i[m] || g[m]) begin
          if ($urandom_range(0, 3) != 0) begin
            bk = (k < 1000) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NB - 1));
            req_i[m]   = 1'b1;
            add_i[m]   = mk_addr(bk, int'($urandom_range(0, 15))) | (32'($urandom) & 32'hFFF8_0003);
            wen_i[m]   = 1'($urandom_range(0, 1));
            wdata_i[m] = 32'($urandom);
            be_i[m]    = 4'($urandom);
          end else begin
            req_i[m] = 1'b0;
          end
        end
      end
      for (int b = 0; b < NB; b++) gnt_i[b] = ($urandom_range(0, 7) != 0);
      @(negedge clk); g = gnt_o;
      @(posedge clk); #1;
    end
    req_i = '0; gnt_i = '1;
    repeat (2) begin @(negedge clk); @(posedge clk); #1; end

    // Reset right after a grant kills its response and rewinds all pointers.
    req_i[0] = 1'b1; add_i[0] = mk_addr(2, 5); wen_i[0] = 1'b0;
    @(negedge clk);
    check("h_gnt0", 0, 64'(gnt_o[0]), 64'd1);
    @(posedge clk); #1 rst_n = 1'b0; req_i = '0;
    @(negedge clk);
    check("h_vld_after_rst", -1, 64'(vld_o), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int m = 0; m < NM; m++) begin
      req_i[m] = 1'b1; add_i[m] = mk_addr(5, m); wen_i[m] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("h_ptr_restart", k, 64'(gnt_o), 64'(1 << k));
      @(posedge clk); #1 req_i[k] = 1'b0;
    end
    req_i = '0;
    repeat (3) begin @(negedge clk); @(posedge clk); #1; end
    for (int m = 0; m < NM; m++) check("pending_left", m, 64'(q[m].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_interconnect_wrap.md
TCDM_INTERCONNECT_WRAP -- requirements
Module: tcdm_interconnect_wrap

Interface
REQ-001 SHALL have parameter NumMaster, default 16: number of master ports; power of 2, at least 2.
REQ-002 SHALL have parameter BankFact, default 2: banking factor; NumBanks = NumMaster*BankFact, power of 2.
REQ-003 SHALL have parameter DataWidth, default 32: data and master address width in bits; multiple of 8.
REQ-004 SHALL have parameter MemAddrBits, default 12: word-address width inside one bank.
REQ-005 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port req_i, input, [NumMaster]: master request.
REQ-008 SHALL have port add_i, input, [NumMaster][DataWidth]: master byte address.
REQ-009 SHALL have port wen_i, input, [NumMaster]: 1 = write, 0 = read.
REQ-010 SHALL have port wdata_i, input, [NumMaster][DataWidth]: write data.
REQ-011 SHALL have port be_i, input, [NumMaster][DataWidth/8]: byte enables.
REQ-012 SHALL have port gnt_o, output, [NumMaster]: request accepted this cycle.
REQ-013 SHALL have port vld_o, output, [NumMaster]: response valid.
REQ-014 SHALL have port rdata_o, output, [NumMaster][DataWidth]: response data.
REQ-015 SHALL have port req_o, output, [NumBanks]: bank chip select.
REQ-016 SHALL have port gnt_i, input, [NumBanks]: bank accepts req_o.
REQ-017 SHALL have port add_o, output, [NumBanks][MemAddrBits]: bank word address.
REQ-018 SHALL have ports wen_o, wdata_o and be_o, outputs, per bank: forwarded from the winning master.
REQ-019 SHALL have port rdata_i, input, [NumBanks][DataWidth]: bank read data, valid one cycle after the bank accepts.

Function
REQ-020 SHALL decode the address as follows:
- Off = clog2(DataWidth-1)-3 byte-offset bits, ignored (Off = 2 for DataWidth 32).
- bank = add_i[Off +: clog2(NumBanks)].
- word = add_i[Off+clog2(NumBanks) +: MemAddrBits].
- Higher address bits are ignored.
REQ-021 SHALL be a full combinational crossbar: any master can reach any bank in the same cycle.
REQ-022 SHALL assert req_o[b] combinationally when at least one master requests bank b.
- add_o, wen_o, wdata_o and be_o of bank b SHALL carry the arbitration winner's fields.
- When no master requests bank b, those fields are don't-care.
REQ-023 SHALL resolve contention with one round-robin arbiter per bank.
- The winner is the first requesting master at or after the priority pointer, searching upward with wrap-around.
REQ-024 SHALL advance a bank's pointer to (winner+1) mod NumMaster only on cycles where req_o[b] & gnt_i[b]; otherwise the pointer holds.
REQ-025 SHALL assert gnt_o[m] = req_i[m] & (m is the winner of its bank) & gnt_i[bank], combinationally in the same cycle.
- Losing masters get gnt_o = 0 and keep requesting; no request is dropped or duplicated.
REQ-026 SHALL assert vld_o[m] exactly one cycle after gnt_o[m] = 1, for both reads and writes.
- rdata_o[m] in that cycle SHALL equal rdata_i of the bank granted in the previous cycle.
REQ-027 SHALL register, per master, the granted flag and bank index for one cycle, then steer rdata_i through a NumBanks:1 mux.
- rdata_o is don't-care when vld_o = 0.
REQ-028 SHALL sustain full throughput: NumMaster conflict-free requests per cycle; back-to-back grants to one master give vld_o on every following cycle.
REQ-029 SHALL serve at most one master per bank per cycle; simultaneous same-bank requests are serialized, one grant per cycle.

Reset
REQ-030 SHALL, while rst_ni = 0, clear vld_o and the response-steering registers, and set all arbiter pointers to 0; rdata_o is don't-care.
REQ-031 SHALL keep the combinational paths (gnt_o, req_o and bank fields) functional during reset.
- Reset mid-operation SHALL drop any pending response: no vld_o in the cycle after reset asserts.

Structure
REQ-032 SHALL compute derived constants (NumBanks, Off, bank-select width) as local parameters; no shared package is required.
REQ-033 SHALL use one reusable sub-module, rr_arb_tree-style "tcdm_rr_arbiter" (NumIn = NumMaster, one-hot or index output), instantiated once per bank.

Verification
REQ-034 Bench: master 0 reads address 0x0000_0104 (bank 1, word 2 when NumBanks = 32) with no contention -> gnt_o[0] = 1 in the same cycle; req_o[1] = 1, add_o[1] = 2, wen_o[1] = 0; next cycle vld_o[0] = 1 and rdata_o[0] = rdata_i[1].
REQ-035 Bench: all 16 masters read distinct banks (m -> bank m) every cycle for 1000 cycles -> every request granted in the same cycle; vld_o = all-ones from the second cycle on.
REQ-036 Bench: masters 0, 3 and 5 continuously request bank 7 -> grants rotate 0, 3, 5, 0, ...; each master's wait count stays at most 2 cycles.
REQ-037 Bench: master 2 writes 0xDEADBEEF with be = 4'b0011 to bank 4, word 9, then reads it back -> bank sees wen_o = 1, be_o = 0011; readback low half = 0xBEEF; a vld_o pulse follows each grant.
REQ-038 Bench: gnt_i[4] = 0 while master 1 requests bank 4 -> gnt_o[1] = 0, no vld_o, pointer unchanged; raising gnt_i[4] grants master 1 in the same cycle.
REQ-039 Bench: assert rst_ni low in the cycle after a grant -> vld_o = 0 immediately; after release, all arbiter pointers restart at master 0.
